mem_port_arbiter: RTL

//  Shares one SRAM-like memory port (req/addr_ok/data_ok split handshake) between the fetch

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_src_order_fifo.sv | 62 ++++++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: command bus layout, requester ids
// and a helper that builds the fixed fetch read command.
package mem_port_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CMD_W  = 71;

    // Command bus layout: {wr, size, wstrb, addr, wdata}
    localparam int CMD_WR_BIT    = 70;
    localparam int CMD_SIZE_LSB  = 68;
    localparam int CMD_WSTRB_LSB = 64;
    localparam int CMD_ADDR_LSB  = 32;
    localparam int CMD_WDATA_LSB = 0;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    function automatic logic [CMD_W-1:0] inst_read_cmd(input logic [ADDR_W-1:0] addr);
        logic [CMD_W-1:0] cmd;
        cmd                                = '0;
        cmd[CMD_WR_BIT]                    = 1'b0;
        cmd[CMD_SIZE_LSB +: 2]             = SIZE_WORD;
        cmd[CMD_WSTRB_LSB +: 4]            = 4'b0000;
        cmd[CMD_ADDR_LSB +: ADDR_W]        = addr;
        cmd[CMD_WDATA_LSB +: DATA_W]       = '0;
        return cmd;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_src_order_fifo.sv
// In-order record of which requester owns each in-flight memory transaction.
// One bit per entry, DEPTH entries, pointers wrap modulo DEPTH.
module src_order_fifo #(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             push_src,
    input  logic             pop,
    output logic             head_src,
    output logic [CNT_W-1:0] count
);
    import mem_port_arbiter_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0] slot_q, slot_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push then.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_d[gi] = (do_push && (wr_ptr_q == PTR_W'(gi))) ? push_src : slot_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_src = slot_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one split-handshake memory port between the fetch and Memory-stage requesters,
// routing each returned data_ok back to the requester that issued the transaction.
module mem_port_arbiter #(
    parameter int OUTS  = 2,
    parameter int CMD_W = mem_port_arbiter_pkg::CMD_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inst_req,
    input  logic [31:0]      inst_addr,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,
    input  logic             data_req,
    input  logic [CMD_W-1:0] data_cmd,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,
    output logic             mem_req,
    output logic [CMD_W-1:0] mem_cmd,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [31:0]      mem_rdata,
    output logic             busy
);
    import mem_port_arbiter_pkg::*;

    localparam int CNT_W = $clog2(OUTS + 1);

    logic             lock_q, lock_d;
    src_e             lock_src_q, lock_src_d;
    src_e             grant;
    logic             grant_req;
    logic [CMD_W-1:0] grant_cmd;
    logic             accept, ret;
    logic             head_src;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;

    src_order_fifo #(
        .DEPTH (OUTS)
    ) u_order (
        .clk      (clk),
        .rstn     (rstn),
        .push     (accept),
        .push_src (grant),
        .pop      (ret),
        .head_src (head_src),
        .count    (fifo_count)
    );

    always_comb begin
        fifo_full  = (fifo_count == CNT_W'(OUTS));
        fifo_empty = (fifo_count == '0);

        // An outstanding unaccepted request pins the grant; otherwise the older Memory stage wins.
        grant     = lock_q ? lock_src_q : (data_req ? SRC_DATA : SRC_INST);
        grant_req = (grant == SRC_DATA) ? data_req : inst_req;
        grant_cmd = (grant == SRC_DATA) ? data_cmd : CMD_W'(inst_read_cmd(inst_addr));

        mem_req = grant_req && !fifo_full;
        mem_cmd = mem_req ? grant_cmd : '0;
        accept  = mem_req && mem_addr_ok;

        inst_addr_ok = accept && (grant == SRC_INST);
        data_addr_ok = accept && (grant == SRC_DATA);

        // Returns are matched against the head before this cycle's push lands.
        ret          = mem_data_ok && !fifo_empty;
        inst_data_ok = ret && (head_src == SRC_INST);
        data_data_ok = ret && (head_src == SRC_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : '0;
        data_rdata   = data_data_ok ? mem_rdata : '0;

        lock_d     = mem_req && !mem_addr_ok;
        lock_src_d = grant;

        busy = !fifo_empty || lock_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INST;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

endmodule
